// File: rtl/uart_tx_sched.sv
// Two-requester round-robin UART transmit scheduler.
// Serialises the granted byte as 8N1/8N2 or with even/odd parity, paced by an external baud tick.
module uart_tx_sched #(
    parameter int STOP_BITS = 1,
    parameter int PARITY    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    input  logic       baud_tick,
    output logic       baud_en,
    output logic       txd,
    output logic       busy,
    output logic       grant_id
);

    localparam bit TwoStop = (STOP_BITS == 2);
    localparam bit ParEn   = (PARITY == 1) || (PARITY == 2);
    localparam bit ParOdd  = (PARITY == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY_ST, STOP} state_t;

    state_t      state;
    logic [7:0]  shiftReg;
    logic [2:0]  bitCnt;
    logic        stopCnt;
    logic        parityBit;
    logic        prefer;
    logic        sel;
    logic        tick;
    logic [7:0]  selData;

    // prefer names the requester that wins a tie, i.e. the one not granted last time
    assign tick       = baud_tick && baud_en;
    assign sel        = (req0_valid && req1_valid) ? prefer : req1_valid;
    assign selData    = sel ? req1_data : req0_data;
    assign req0_ready = !reset && (state == IDLE) && req0_valid && !sel;
    assign req1_ready = !reset && (state == IDLE) && req1_valid && sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shiftReg  <= 8'h00;
            bitCnt    <= 3'd0;
            stopCnt   <= 1'b0;
            parityBit <= 1'b0;
            prefer    <= 1'b0;
            txd       <= 1'b1;
            baud_en   <= 1'b0;
            busy      <= 1'b0;
            grant_id  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        shiftReg  <= selData;
                        grant_id  <= sel;
                        parityBit <= (^selData) ^ ParOdd;
                        prefer    <= !sel;
                        state     <= START;
                        txd       <= 1'b0;
                        baud_en   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state  <= DATA;
                        bitCnt <= 3'd0;
                        txd    <= shiftReg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shiftReg <= {1'b0, shiftReg[7:1]};
                        if (bitCnt == 3'd7) begin
                            if (ParEn) begin
                                state <= PARITY_ST;
                                txd   <= parityBit;
                            end else begin
                                state   <= STOP;
                                txd     <= 1'b1;
                                stopCnt <= 1'b0;
                            end
                        end else begin
                            bitCnt <= bitCnt + 3'd1;
                            txd    <= shiftReg[1];
                        end
                    end
                end
                PARITY_ST: begin
                    if (tick) begin
                        state   <= STOP;
                        txd     <= 1'b1;
                        stopCnt <= 1'b0;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stopCnt == TwoStop) begin
                            state   <= IDLE;
                            baud_en <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            stopCnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    txd     <= 1'b1;
                    baud_en <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: three instances (8N1, 8E1, 8O2) against a frame/arbitration model.
module tb_uart_tx_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] v0, v1;
    logic [7:0] dat0 [3];
    logic [7:0] dat1 [3];
    logic [2:0] autoTick;
    logic       stray;
    wire  [2:0] tick;
    wire  [2:0] rdy0, rdy1, baudEn, txd, busy, gid;

    int checks   = 0;
    int failures = 0;
    int lastGnt [3];
    int lastWait;
    int tcnt [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_tx_sched #(.STOP_BITS((g == 2) ? 2 : 1), .PARITY(g)) u (
            .clk(clk), .reset(reset),
            .req0_valid(v0[g]), .req0_data(dat0[g]), .req0_ready(rdy0[g]),
            .req1_valid(v1[g]), .req1_data(dat1[g]), .req1_ready(rdy1[g]),
            .baud_tick(tick[g]), .baud_en(baudEn[g]), .txd(txd[g]),
            .busy(busy[g]), .grant_id(gid[g])
        );
    end

    // Tick generator: one tick every 4 cycles, phase restarted whenever baud_en is low
    assign tick = autoTick | {3{stray}};
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            if (!baudEn[k]) begin
                tcnt[k]     = 0;
                autoTick[k] = 1'b0;
            end else begin
                tcnt[k]     = tcnt[k] + 1;
                autoTick[k] = (tcnt[k] == 4);
                if (tcnt[k] == 4) tcnt[k] = 0;
            end
        end
    end

    // Frame model: instance k has parity mode k and k==2 uses two stop bits
    task automatic buildFrame(input int k, input logic [7:0] b, output logic [15:0] bits, output int n);
        int ones;
        bits = '1;
        ones = 0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bits[1 + i] = b[i];
            ones += b[i];
        end
        n = 9;
        if (k == 1) begin bits[n] = ((ones % 2) == 1); n++; end
        if (k == 2) begin bits[n] = ((ones % 2) == 0); n++; end
        n += (k == 2) ? 2 : 1;
    endtask

    task automatic doReset();
        v0 = '0;
        v1 = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) lastGnt[k] = 1;
    endtask

    task automatic runFrame(input int k, input int r, input logic [7:0] b, input bit hold);
        logic [15:0] bits;
        int   n;
        int   waited;
        logic rs, ro;
        buildFrame(k, b, bits, n);
        if (r == 0) begin dat0[k] = b; v0[k] = 1'b1; end
        else        begin dat1[k] = b; v1[k] = 1'b1; end
        #1;
        waited = 0;
        while (((r == 0) ? rdy0[k] : rdy1[k]) !== 1'b1 && waited < 200) begin
            @(negedge clk); #1;
            waited++;
        end
        lastWait = waited;
        rs = (r == 0) ? rdy0[k] : rdy1[k];
        ro = (r == 0) ? rdy1[k] : rdy0[k];
        checks++;
        if ({rs, ro} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL accept dut%0d req%0d: ready self/other=%b%b required 10 (waited %0d)", k, r, rs, ro, waited);
            v0[k] = 1'b0;
            v1[k] = 1'b0;
            return;
        end
        lastGnt[k] = r;
        @(negedge clk);
        if (!hold) begin
            if (r == 0) v0[k] = 1'b0; else v1[k] = 1'b0;
        end
        #1;
        checks++;
        if (((r == 0) ? rdy0[k] : rdy1[k]) !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ready_pulse dut%0d req%0d: ready=1 required 0 one cycle after accept", k, r);
        end
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if ({txd[k], busy[k], baudEn[k], gid[k]} !== {bits[i], 1'b1, 1'b1, r[0]}) begin
                    failures++;
                    $display("[TB] FAIL frame dut%0d byte %h bit%0d cyc%0d: txd/busy/en/gid=%b%b%b%b required %b11%b",
                             k, b, i, c, txd[k], busy[k], baudEn[k], gid[k], bits[i], r[0]);
                end
                @(negedge clk); #1;
            end
        end
        checks++;
        if ({txd[k], busy[k], baudEn[k], gid[k]} !== {3'b100, r[0]}) begin
            failures++;
            $display("[TB] FAIL frame_end dut%0d: txd/busy/en/gid=%b%b%b%b required 100%b",
                     k, txd[k], busy[k], baudEn[k], gid[k], r[0]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        v0 = 3'b111;
        v1 = 3'b111;
        @(negedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({txd[k], baudEn[k], busy[k], gid[k], rdy0[k], rdy1[k]} !== 6'b100000) begin
                failures++;
                $display("[TB] FAIL reset dut%0d: txd/en/busy/gid/rdy0/rdy1=%b%b%b%b%b%b required 100000",
                         k, txd[k], baudEn[k], busy[k], gid[k], rdy0[k], rdy1[k]);
            end
        end
        doReset();
    endtask

    task automatic test_single();
        runFrame(0, 0, 8'hA5, 1'b0);
    endtask

    task automatic test_back_to_back();
        int r;
        reset = 1'b1;
        dat0[0] = 8'h11; dat1[0] = 8'h22;
        v0[0] = 1'b1;    v1[0] = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) lastGnt[k] = 1;
        for (int f = 0; f < 4; f++) begin
            r = 1 - lastGnt[0];
            runFrame(0, r, (r == 0) ? 8'h11 : 8'h22, 1'b1);
            if (f > 0) begin
                checks++;
                if (lastWait != 0) begin
                    failures++;
                    $display("[TB] FAIL idle_gap frame%0d: extra idle cycles=%0d required 0", f, lastWait);
                end
            end
        end
        v0[0] = 1'b0;
        v1[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_parity();
        runFrame(1, 0, 8'h07, 1'b0);
        runFrame(2, 1, 8'h07, 1'b0);
        runFrame(2, 0, 8'hFF, 1'b0);
    endtask

    task automatic test_random();
        int k, w;
        logic [7:0] b, b2;
        for (int it = 0; it < 12; it++) begin
            k  = $urandom_range(0, 2);
            b  = 8'($urandom);
            b2 = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                w = 1 - lastGnt[k];
                if (w == 0) begin dat1[k] = b2; v1[k] = 1'b1; end
                else        begin dat0[k] = b2; v0[k] = 1'b1; end
                runFrame(k, w, b, 1'b0);
                runFrame(k, 1 - w, b2, 1'b0);
            end else begin
                runFrame(k, $urandom_range(0, 1), b, 1'b0);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        b = 8'($urandom) & 8'hF7;
        dat0[0] = b;
        v0[0] = 1'b1;
        #1;
        while (rdy0[0] !== 1'b1) begin @(negedge clk); #1; end
        @(negedge clk);
        v0[0] = 1'b0;
        repeat (18) @(negedge clk);
        #1;
        checks++;
        if ({txd[0], busy[0]} !== {b[3], 1'b1}) begin
            failures++;
            $display("[TB] FAIL pre_reset_bit3: txd/busy=%b%b required %b1", txd[0], busy[0], b[3]);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({txd[0], baudEn[0], busy[0]} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL async_reset: txd/en/busy=%b%b%b required 100", txd[0], baudEn[0], busy[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) lastGnt[k] = 1;
        runFrame(0, 1, 8'h3C, 1'b0);
    endtask

    task automatic test_stray_tick();
        doReset();
        stray = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({txd[k], baudEn[k], busy[k]} !== 3'b100) begin
                    failures++;
                    $display("[TB] FAIL stray_tick dut%0d: txd/en/busy=%b%b%b required 100", k, txd[k], baudEn[k], busy[k]);
                end
            end
        end
        stray = 1'b0;
        @(negedge clk);
        runFrame(0, 0, 8'($urandom), 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        stray = 1'b0;
        autoTick = '0;
        v0 = '0;
        v1 = '0;
        for (int k = 0; k < 3; k++) begin
            dat0[k] = 8'h00;
            dat1[k] = 8'h00;
            tcnt[k] = 0;
            lastGnt[k] = 1;
        end
        #2;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_random();
        test_reset_midframe();
        test_stray_tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] timeout");
    end

endmodule
